// File: rtl/fifo_rr_reader.sv
// fifo_rr_reader: read-side controller for a bank of four source FIFOs.
// It drains the four queues round-robin into one tagged output stream. A pop is
// issued only in ACTIVE state while the destination is not almost full. The
// popped word is captured RD_LAT cycles later from the source FIFO's data_out.
//
// Ports:
//   clk           system clock, rising edge
//   reset_L       asynchronous active-low reset
//   state         system state word (0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE)
//   empty         per-queue empty flags, bit i = queue i
//   fifo_data     per-queue data_out, queue i on [i*DATA_W +: DATA_W]
//   dest_alm_full destination almost-full; blocks new pops
//   pop           one-hot (or zero) pop to the source queues, combinational
//   data_out      forwarded word, registered
//   valid_out     one-cycle pulse per forwarded word, registered
//   src_id        source queue of data_out, registered
//   word_cnt      words forwarded since reset, wraps at 256
//   idle          all queues empty and nothing in flight, combinational
module fifo_rr_reader #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [3:0]            state,
   input  logic [3:0]            empty,
   input  logic [4*DATA_W-1:0]   fifo_data,
   input  logic                  dest_alm_full,
   output logic [3:0]            pop,
   output logic [DATA_W-1:0]     data_out,
   output logic                  valid_out,
   output logic [1:0]            src_id,
   output logic [7:0]            word_cnt,
   output logic                  idle
);

   localparam logic [3:0] StReset  = 4'b0001;
   localparam logic [3:0] StActive = 4'b1000;

   logic                     en;
   logic                     grant_found;
   logic [1:0]               grant_id;
   logic [1:0]               idx;
   logic [DATA_W-1:0]        lane [4];

   logic [1:0]               last_q, last_d;
   logic [RD_LAT-1:0]        pipe_v_q, pipe_v_d;
   logic [RD_LAT-1:0][1:0]   pipe_id_q, pipe_id_d;
   logic [DATA_W-1:0]        data_q, data_d;
   logic                     valid_q, valid_d;
   logic [1:0]               src_q, src_d;
   logic [7:0]               cnt_q, cnt_d;

   // reset_L is folded in so pop drops combinationally during async reset.
   assign en = reset_L & (state == StActive) & ~dest_alm_full;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane[i] = fifo_data[i*DATA_W +: DATA_W];
      end
   end

   // Search last+1 .. last+4 so the most recently served queue is checked last.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = last_q;
      idx         = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!grant_found && !empty[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   assign pop  = (en && grant_found) ? (4'b0001 << grant_id) : 4'b0000;
   assign idle = (&empty) & ~(|pipe_v_q);

   always_comb begin
      last_d    = last_q;
      pipe_v_d  = pipe_v_q;
      pipe_id_d = pipe_id_q;
      data_d    = data_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      valid_d   = pipe_v_q[RD_LAT-1];

      if (|pop) begin
         last_d = grant_id;
      end

      // Stage 0 holds the pop issued this cycle; the last stage lines up with
      // the cycle in which the source FIFO presents the popped word.
      pipe_v_d[0]  = |pop;
      pipe_id_d[0] = grant_id;
      for (int s = 1; s < RD_LAT; s++) begin
         pipe_v_d[s]  = pipe_v_q[s-1];
         pipe_id_d[s] = pipe_id_q[s-1];
      end

      if (pipe_v_q[RD_LAT-1]) begin
         data_d = lane[pipe_id_q[RD_LAT-1]];
         src_d  = pipe_id_q[RD_LAT-1];
         cnt_d  = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         last_q    <= 2'd3;
         pipe_v_q  <= '0;
         pipe_id_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         src_q     <= 2'd0;
         cnt_q     <= 8'd0;
      end else if (state == StReset) begin
         last_q    <= 2'd3;
         pipe_v_q  <= '0;
         pipe_id_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         src_q     <= 2'd0;
         cnt_q     <= 8'd0;
      end else begin
         last_q    <= last_d;
         pipe_v_q  <= pipe_v_d;
         pipe_id_q <= pipe_id_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         src_q     <= src_d;
         cnt_q     <= cnt_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign src_id    = src_q;
   assign word_cnt  = cnt_q;

endmodule
